// File: rtl/fifo16_buffer_if.sv
// Producer/consumer bus of fifo16_buffer. Defining FIFO16_ERR_FLAGS_EN adds the
// sticky overflow/underflow status lines.
interface fifo16_buffer_if #(
    parameter int BUF_WIDTH  = 4,
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] buf_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] uH;
    logic [DATA_WIDTH-1:0] uL;
    logic [DATA_WIDTH-1:0] buf_out;
    logic                  buf_empty;
    logic                  buf_full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [BUF_WIDTH:0]    fifo_counter;
`ifdef FIFO16_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output buf_in, wr_en, rd_en, uH, uL,
`ifdef FIFO16_ERR_FLAGS_EN
        input  overflow, underflow,
`endif
        input  buf_out, buf_empty, buf_full, almost_full, almost_empty, fifo_counter
    );

    modport slave (
        input  buf_in, wr_en, rd_en, uH, uL,
`ifdef FIFO16_ERR_FLAGS_EN
        output overflow, underflow,
`endif
        output buf_out, buf_empty, buf_full, almost_full, almost_empty, fifo_counter
    );
endinterface

// File: rtl/fifo16_buffer.sv
// Single-clock FIFO with registered read port, programmable almost-full/empty flags
// and exported occupancy. Optional sticky error flags under FIFO16_ERR_FLAGS_EN.
module fifo16_buffer #(
    parameter int BUF_WIDTH  = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fifo16_buffer_if.slave bus
);
    localparam int DEPTH = 1 << BUF_WIDTH;
    localparam int CW    = ((DATA_WIDTH > BUF_WIDTH + 1) ? DATA_WIDTH : BUF_WIDTH + 1) + 1;
    localparam logic [BUF_WIDTH:0]   CNT_ZERO  = (BUF_WIDTH + 1)'(0);
    localparam logic [BUF_WIDTH:0]   CNT_ONE   = (BUF_WIDTH + 1)'(1);
    localparam logic [BUF_WIDTH:0]   CNT_DEPTH = (BUF_WIDTH + 1)'(DEPTH);
    localparam logic [BUF_WIDTH-1:0] PTR_ZERO  = BUF_WIDTH'(0);
    localparam logic [BUF_WIDTH-1:0] PTR_ONE   = BUF_WIDTH'(1);
    localparam logic [CW-1:0]        DEPTH_EXT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [BUF_WIDTH-1:0]  wr_ptr_r;
    logic [BUF_WIDTH-1:0]  rd_ptr_r;
    logic [BUF_WIDTH:0]    count_r;
    logic [DATA_WIDTH-1:0] out_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  almost_full_s;
    logic                  almost_empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [CW-1:0]         cnt_ext_s;
    logic [CW-1:0]         uh_ext_s;
    logic [CW-1:0]         ul_ext_s;

    // Status flags and accept qualifiers, all derived from the occupancy count.
    always_comb begin
        cnt_ext_s = CW'(count_r);
        uh_ext_s  = CW'(bus.uH);
        ul_ext_s  = CW'(bus.uL);
        empty_s   = (count_r == CNT_ZERO);
        full_s    = (count_r == CNT_DEPTH);
        // count >= DEPTH-uH rewritten as count+uH >= DEPTH so uH >= DEPTH cannot underflow
        almost_full_s  = ((cnt_ext_s + uh_ext_s) >= DEPTH_EXT);
        almost_empty_s = (cnt_ext_s <= ul_ext_s);
        wr_acc_s  = bus.wr_en & ~full_s;
        rd_acc_s  = bus.rd_en & ~empty_s;
    end

    // Storage array; deliberately not reset so stale words survive rst.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.buf_in;
        end
    end

    // Pointers, occupancy counter and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            out_r    <= DATA_WIDTH'(0);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                out_r    <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.buf_out      = out_r;
    assign bus.buf_empty    = empty_s;
    assign bus.buf_full     = full_s;
    assign bus.almost_full  = almost_full_s;
    assign bus.almost_empty = almost_empty_s;
    assign bus.fifo_counter = count_r;

`ifdef FIFO16_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky misuse flags; a full-write paired with an accepted read is legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.wr_en && full_s && !rd_acc_s) begin
                overflow_r <= 1'b1;
            end
            if (bus.rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_fifo16_buffer.sv
// Directed-vector bench for fifo16_buffer: stimulus queues expected read data,
// a monitor process pops and compares it after every accepted read.
module tb_fifo16_buffer;
    localparam int BW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo16_buffer_if #(.BUF_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    fifo16_buffer #(.BUF_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] model_q[$];
    logic [3:0] sb_q[$];
    bit         chk_rd  = 1'b0;
    logic [3:0] last_rd = 4'h0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one cycle after an accepted read is issued, buf_out must hold the queued word.
    initial begin
        forever begin
            @(posedge clk);
            if (chk_rd) begin
                #1;
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rdata: got %0d expected <no queued word>", bus.buf_out);
                end else begin
                    chk("rdata", int'(bus.buf_out), int'(sb_q.pop_front()));
                end
            end
        end
    end

    // Flags expected for uH=2, uL=3 on a 16-deep FIFO.
    task automatic check_status();
        int n;
        n = model_q.size();
        chk("fifo_counter", int'(bus.fifo_counter), n);
        chk("buf_empty",    int'(bus.buf_empty),    (n == 0)  ? 1 : 0);
        chk("buf_full",     int'(bus.buf_full),     (n == 16) ? 1 : 0);
        chk("almost_full",  int'(bus.almost_full),  (n >= 14) ? 1 : 0);
        chk("almost_empty", int'(bus.almost_empty), (n <= 3)  ? 1 : 0);
    endtask

    task automatic step(input bit w, input bit r, input logic [3:0] d);
        bit wa;
        bit ra;
        @(negedge clk);
        ra = r && (model_q.size() > 0);
        wa = w && (model_q.size() < DEPTH);
        bus.wr_en  = w;
        bus.rd_en  = r;
        bus.buf_in = d;
        chk_rd     = ra;
        if (ra) begin
            last_rd = model_q.pop_front();
            sb_q.push_back(last_rd);
        end
        if (wa) begin
            model_q.push_back(d);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk_rd    = 1'b0;
        check_status();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.buf_in = 4'h0;
        bus.uH     = 4'd2;
        bus.uL     = 4'd3;
        #12;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_counter", int'(bus.fifo_counter), 0);
        chk("reset_empty",   int'(bus.buf_empty), 1);
        chk("reset_full",    int'(bus.buf_full), 0);
        chk("reset_aempty",  int'(bus.almost_empty), 1);
        chk("reset_afull",   int'(bus.almost_full), 0);
        chk("reset_buf_out", int'(bus.buf_out), 0);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("reset_overflow",  int'(bus.overflow), 0);
        chk("reset_underflow", int'(bus.underflow), 0);
`endif

        // Basic push/pop, including a simultaneous push+pop.
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b1, 4'h2);
        chk("pp_counter", int'(bus.fifo_counter), 1);
        chk("pp_buf_out", int'(bus.buf_out), 1);
        step(1'b0, 1'b1, 4'h0);
        chk("pop2_buf_out", int'(bus.buf_out), 2);
        chk("pop2_empty",   int'(bus.buf_empty), 1);

        // Push+pop while empty: only the write lands, buf_out holds.
        step(1'b1, 1'b1, 4'h3);
        chk("empty_pp_buf_out", int'(bus.buf_out), 2);
        chk("empty_pp_counter", int'(bus.fifo_counter), 1);
        step(1'b0, 1'b1, 4'h0);

        // Fill to full.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'(i * 3 + 1));
        end
        chk("fill_full",    int'(bus.buf_full), 1);
        chk("fill_counter", int'(bus.fifo_counter), 16);

        // Push+pop while full: only the read lands, no overflow.
        step(1'b1, 1'b1, 4'h9);
        chk("full_pp_counter", int'(bus.fifo_counter), 15);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("full_pp_overflow", int'(bus.overflow), 0);
`endif
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'hF);
        chk("over_counter", int'(bus.fifo_counter), 16);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("overflow_set", int'(bus.overflow), 1);
`endif

        // Drain; last word is 4'h7 (after words 4..46 mod 16 and the refill).
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h0);
        end
        chk("drain_empty",   int'(bus.buf_empty), 1);
        chk("drain_buf_out", int'(bus.buf_out), 7);
        step(1'b0, 1'b1, 4'h0);
        chk("extra_pop_buf_out", int'(bus.buf_out), 7);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("underflow_set", int'(bus.underflow), 1);
`endif

        // Wrap-around: interleaved traffic well past 16 writes.
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 4'(i + 5));
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 4'hC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'(15 - i));
        chk("wrap_full", int'(bus.buf_full), 1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'h0);

        // Reset between edges with 5 words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 2));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_counter", int'(bus.fifo_counter), 0);
        chk("midrst_empty",   int'(bus.buf_empty), 1);
        chk("midrst_buf_out", int'(bus.buf_out), 0);
        rst = 1'b0;
        model_q.delete();
        step(1'b1, 1'b0, 4'hA);
        step(1'b0, 1'b1, 4'h0);
        chk("post_rst_buf_out", int'(bus.buf_out), 10);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("post_rst_overflow",  int'(bus.overflow), 0);
        chk("post_rst_underflow", int'(bus.underflow), 0);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
